gray_seq_ctrl: RTL
==================

Name: gray_seq_ctrl

Overview:
- Sequencer for the team's binary-to-Gray converter datapath.
- Steps a binary code through a configured range in either direction and drives the converter's binary input.
- Captures each converted Gray word and presents it as a binary/Gray pair on a valid/ready output stream.
- Used wherever Gray-coded sequences are generated, e.g. pointer/position pattern generation and converter self-test.

Parameters:
- WIDTH, 4, code width of the binary and Gray words.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
- abort  input  1  synchronous abort; returns the block to IDLE from any state.
- cfg_first  input  WIDTH  first binary value; latched on accepted start.
- cfg_last  input  WIDTH  last binary value; latched on accepted start.
- cfg_down  input  1  0 = increment, 1 = decrement; latched on accepted start.
- cfg_loop  input  1  1 = restart at first after last; latched on accepted start.
- bin_out  output  WIDTH  registered binary value driven to the converter input.
- gray_in  input  WIDTH  Gray result from the converter; combinational function of bin_out.
- out_valid  output  1  out_bin/out_gray hold a valid pair.
- out_ready  input  1  consumer accepts the pair.
- out_bin  output  WIDTH  registered binary value of the presented pair.
- out_gray  output  WIDTH  registered Gray value of the presented pair.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last pair of a non-loop sequence is accepted.

Behaviour:
- Reset: state IDLE; bin_out, out_bin, out_gray, latched cfg all 0; out_valid, busy, done 0. Reset overrides start and abort.
- States: IDLE, CONV, EMIT.
- IDLE:
  - On start=1 and abort=0: latch cfg_*, set bin_out <= cfg_first, go to CONV.
  - start while busy is ignored.
- CONV (exactly 1 cycle, converter settle):
  - out_bin <= bin_out, out_gray <= gray_in, out_valid <= 1.
  - Go to EMIT.
- EMIT:
  - out_valid stays 1 and out_bin/out_gray stay stable until out_valid & out_ready.
  - On handshake, if out_bin == last and loop = 1: bin_out <= first, out_valid <= 0, go to CONV.
  - On handshake, if out_bin == last and loop = 0: out_valid <= 0, done <= 1 for one cycle, go to IDLE.
  - Otherwise: bin_out <= bin_out + 1 (down=0) or bin_out - 1 (down=1), modulo 2^WIDTH; out_valid <= 0; go to CONV.
- Timing:
  - Throughput is one pair per 2 cycles with out_ready held high.
  - First out_valid is asserted 2 cycles after the start cycle.
- Wrap-around: the range is followed modulo 2^WIDTH in the selected direction.
  - Up, first=14, last=1 gives 14, 15, 0, 1.
  - first == last emits exactly one pair (non-loop).
- abort (any state, synchronous): next cycle state=IDLE, out_valid=0, busy=0, done=0. bin_out, out_bin, out_gray keep their last values. If abort and start are high together in IDLE, abort wins.
- cfg_* changes while busy have no effect.
- done never coincides with out_valid=1.

Test Plan:
- Up, first=0, last=15, loop=0, ready=1 -> out_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; pairs 2 cycles apart; done pulses once; busy then falls.
- Down wrap, first=1, last=14, down=1 -> out_bin 1,0,F,E with out_gray 1,0,8,9; then done.
- Backpressure: first=3, last=5, out_ready low 4 cycles on the second pair -> out_bin=4/out_gray=6 held stable, no skipped or duplicated pair; sequence 3/2, 4/6, 5/7.
- Loop: first=6, last=7, loop=1 -> pairs 6/5, 7/4, 6/5, 7/4 repeating; done never asserts; abort ends it with out_valid=0 next cycle.
- Abort vs start: abort during EMIT -> IDLE, no done; start+abort same cycle in IDLE -> stays IDLE; start while busy -> ignored.
- Reset mid-sequence and first==last=9 -> after rst all outputs 0; a fresh start with 9/9 yields a single pair 9/D, then done.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// Sequencer for the binary-to-Gray converter datapath: steps a binary code through
// a configured range, captures the converted Gray word and emits binary/Gray pairs.
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_first,
  input  logic [WIDTH-1:0] cfg_last,
  input  logic             cfg_down,
  input  logic             cfg_loop,
  output logic [WIDTH-1:0] bin_out,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic [WIDTH-1:0] out_gray_q, out_gray_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             down_q, down_d;
  logic             loop_q, loop_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    out_bin_d   = out_bin_q;
    out_gray_d  = out_gray_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    first_d     = first_q;
    last_d      = last_q;
    down_d      = down_q;
    loop_d      = loop_q;

    if (abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            first_d = cfg_first;
            last_d  = cfg_last;
            down_d  = cfg_down;
            loop_d  = cfg_loop;
            bin_d   = cfg_first;
            state_d = S_CONV;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CONV: begin
          // One cycle lets the converter settle on bin_q before capture.
          out_bin_d   = bin_q;
          out_gray_d  = gray_in;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
        S_EMIT: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (out_bin_q == last_q) begin
              if (loop_q) begin
                bin_d   = first_q;
                state_d = S_CONV;
              end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              bin_d   = down_q ? (bin_q - STEP_ONE) : (bin_q + STEP_ONE);
              state_d = S_CONV;
            end
          end else begin
            state_d = S_EMIT;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= ZERO;
      out_bin_q   <= ZERO;
      out_gray_q  <= ZERO;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      first_q     <= ZERO;
      last_q      <= ZERO;
      down_q      <= 1'b0;
      loop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      out_bin_q   <= out_bin_d;
      out_gray_q  <= out_gray_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      first_q     <= first_d;
      last_q      <= last_d;
      down_q      <= down_d;
      loop_q      <= loop_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_bin   = out_bin_q;
  assign out_gray  = out_gray_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
